// File: rtl/adpcm_pkg.sv
// rtl/adpcm_pkg.sv - IMA ADPCM step/index tables and encoder FSM states
package adpcm_pkg;

  localparam int IDX_MAX = 88;

  // IMA step sizes indexed by the 0..88 step index
  localparam logic [14:0] STEP_TABLE [0:88] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  // Step index adjustment per code magnitude; +8 needs a 5-bit signed field
  localparam logic signed [4:0] INDEX_ADJ [0:7] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_QUANT,
    ST_UPDATE,
    ST_OUT
  } state_t;

  // Step lookup that stays in range even if an index ever exceeds IDX_MAX
  function automatic logic [14:0] step_of(input logic [6:0] idx);
    if (idx > 7'(IDX_MAX)) return STEP_TABLE[IDX_MAX];
    return STEP_TABLE[idx];
  endfunction

endpackage

// File: rtl/adpcm_chan_state.sv
// rtl/adpcm_chan_state.sv - per-channel predictor/step-index register file
module adpcm_chan_state #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH_W-1:0] i_rd_ch,
  output logic [15:0]     o_rd_pred,
  output logic [6:0]      o_rd_idx,
  input  logic            i_wr_en,
  input  logic [CH_W-1:0] i_wr_ch,
  input  logic [15:0]     i_wr_pred,
  input  logic [6:0]      i_wr_idx,
  input  logic            i_clr_en,
  input  logic [CH_W-1:0] i_clr_ch
);

  logic [15:0] r_pred [CHANNELS];
  logic [6:0]  r_idx  [CHANNELS];

  // Combinational read; unmatched tags read as zero
  always_comb begin
    o_rd_pred = '0;
    o_rd_idx  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i_rd_ch == CH_W'(i)) begin
        o_rd_pred = r_pred[i];
        o_rd_idx  = r_idx[i];
      end
    end
  end

  // Write port; a clear to the same channel overrides the write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_pred[i] <= '0;
        r_idx[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (i_clr_en && (i_clr_ch == CH_W'(i))) begin
          r_pred[i] <= '0;
          r_idx[i]  <= '0;
        end else if (i_wr_en && (i_wr_ch == CH_W'(i))) begin
          r_pred[i] <= i_wr_pred;
          r_idx[i]  <= i_wr_idx;
        end
      end
    end
  end

endmodule

// File: rtl/adpcm_encoder_mc.sv
// rtl/adpcm_encoder_mc.sv - multi-channel IMA ADPCM encoder with 3-cycle quantiser
module adpcm_encoder_mc #(
  parameter int CHANNELS = 4,
  parameter int SAMPLE_W = 16,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic [CH_W-1:0]     in_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_code,
  output logic [CH_W-1:0]     out_ch,
  output logic [15:0]         out_pred,
  input  logic                clr_valid,
  input  logic [CH_W-1:0]     clr_ch
);
  import adpcm_pkg::*;

  state_t          r_state;
  logic            r_in_ready;
  logic [15:0]     r_s16;
  logic [CH_W-1:0] r_ch;
  logic            r_wb;
  logic            r_clr_pend;
  logic            r_sign;
  logic [16:0]     r_mag;
  logic [14:0]     r_step;
  logic [16:0]     r_vpdiff;
  logic [2:0]      r_code;
  logic [1:0]      r_k;
  logic [15:0]     r_pred;
  logic [6:0]      r_idx;
  logic            r_out_valid;
  logic [3:0]      r_out_code;
  logic [CH_W-1:0] r_out_ch;
  logic [15:0]     r_out_pred;

  logic [CH_W-1:0] w_rd_ch;
  logic [15:0]     w_rd_pred;
  logic [6:0]      w_rd_idx;
  logic [16:0]     w_diff;
  logic            w_neg;
  logic [16:0]     w_mag;
  logic [14:0]     w_step_ld;
  logic [17:0]     w_sum;
  logic [15:0]     w_pred_new;
  logic [8:0]      w_idx_sum;
  logic [6:0]      w_idx_new;
  logic            w_we;

  // Out-of-range channel tags quantise against channel 0 and never write back
  assign w_rd_ch = r_wb ? r_ch : '0;
  assign w_we    = (r_state == ST_UPDATE) && r_wb && !r_clr_pend;

  adpcm_chan_state #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_state (
    .clk       (clk),
    .rst       (rst),
    .i_rd_ch   (w_rd_ch),
    .o_rd_pred (w_rd_pred),
    .o_rd_idx  (w_rd_idx),
    .i_wr_en   (w_we),
    .i_wr_ch   (r_ch),
    .i_wr_pred (w_pred_new),
    .i_wr_idx  (w_idx_new),
    .i_clr_en  (clr_valid),
    .i_clr_ch  (clr_ch)
  );

  // Difference, magnitude and initial step for the LOAD cycle
  always_comb begin
    w_diff    = {r_s16[15], r_s16} - {w_rd_pred[15], w_rd_pred};
    w_neg     = w_diff[16];
    w_mag     = w_neg ? (17'd0 - w_diff) : w_diff;
    w_step_ld = step_of(w_rd_idx);
  end

  // Saturating predictor and clamped step index for the UPDATE cycle
  always_comb begin
    if (r_sign) w_sum = {{2{r_pred[15]}}, r_pred} - {1'b0, r_vpdiff};
    else        w_sum = {{2{r_pred[15]}}, r_pred} + {1'b0, r_vpdiff};
    if (!w_sum[17] && (w_sum[16:15] != 2'b00))     w_pred_new = 16'h7FFF;
    else if (w_sum[17] && (w_sum[16:15] != 2'b11)) w_pred_new = 16'h8000;
    else                                           w_pred_new = w_sum[15:0];
    w_idx_sum = {2'b00, r_idx} + {{4{INDEX_ADJ[r_code][4]}}, INDEX_ADJ[r_code]};
    if (w_idx_sum[8])                   w_idx_new = 7'd0;
    else if (w_idx_sum > 9'(IDX_MAX))   w_idx_new = 7'(IDX_MAX);
    else                                w_idx_new = w_idx_sum[6:0];
  end

  // Encoder FSM: IDLE -> LOAD -> QUANT x3 -> UPDATE -> OUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_s16       <= '0;
      r_ch        <= '0;
      r_wb        <= 1'b0;
      r_clr_pend  <= 1'b0;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_step      <= '0;
      r_vpdiff    <= '0;
      r_code      <= '0;
      r_k         <= '0;
      r_pred      <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_code  <= '0;
      r_out_ch    <= '0;
      r_out_pred  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_s16      <= 16'(in_sample) << (16 - SAMPLE_W);
            r_ch       <= in_ch;
            r_wb       <= (int'(in_ch) < CHANNELS);
            r_clr_pend <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_pred   <= w_rd_pred;
          r_idx    <= w_rd_idx;
          r_sign   <= w_neg;
          r_mag    <= w_mag;
          r_step   <= w_step_ld;
          r_vpdiff <= {5'd0, w_step_ld[14:3]};
          r_code   <= '0;
          r_k      <= 2'd2;
          r_state  <= ST_QUANT;
        end
        ST_QUANT: begin
          if (r_mag >= {2'b00, r_step}) begin
            r_code   <= r_code | (3'b001 << r_k);
            r_mag    <= r_mag - {2'b00, r_step};
            r_vpdiff <= r_vpdiff + {2'b00, r_step};
          end
          r_step <= r_step >> 1;
          if (r_k == 2'd0) r_state <= ST_UPDATE;
          else             r_k     <= r_k - 2'd1;
        end
        ST_UPDATE: begin
          r_out_valid <= 1'b1;
          r_out_code  <= {r_sign, r_code};
          r_out_ch    <= r_ch;
          r_out_pred  <= w_pred_new;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A clear aimed at the in-flight channel must survive the UPDATE write
      if (clr_valid && r_wb && (clr_ch == r_ch) &&
          ((r_state == ST_LOAD) || (r_state == ST_QUANT)))
        r_clr_pend <= 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_code  = r_out_code;
  assign out_ch    = r_out_ch;
  assign out_pred  = r_out_pred;

endmodule
